// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle adder: accepts two WIDTH-bit operands over a valid/ready
// handshake and adds them one nibble per clock through a single
// four_bit_adder. The carry between nibbles is held in a register. The
// result is presented with out_valid until the consumer takes it.
//
// Optional feature macro: NIBBLE_SERIAL_ADDER_OVF_EN
//    defined   -> two's-complement overflow register drives out_ovf
//    undefined -> overflow logic omitted, out_ovf tied to 0
//
// Ports (nibble_serial_adder):
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   operand request
//    in_ready   out  operands accepted (high only while idle)
//    in_a       in   operand A [WIDTH]
//    in_b       in   operand B [WIDTH]
//    in_cin     in   carry into bit 0
//    out_valid  out  result available (high only when done)
//    out_ready  in   consumer takes the result
//    out_sum    out  sum modulo 2^WIDTH [WIDTH]
//    out_cout   out  carry out of bit WIDTH-1
//    out_ovf    out  two's-complement overflow flag
//
// Ports (four_bit_adder): A, B, Cin -> Sum, Cout (combinational ripple)
// -----------------------------------------------------------------------------

module four_bit_adder (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout
);

   logic [4:0] carry;

   // Explicit ripple chain of four full adders.
   always_comb begin
      carry    = '0;
      Sum      = '0;
      carry[0] = Cin;
      for (int i = 0; i < 4; i++) begin
         Sum[i]       = A[i] ^ B[i] ^ carry[i];
         carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
      end
   end

   assign Cout = carry[4];

endmodule

module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opA_q;
   logic [WIDTH-1:0] opB_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic [IDXW-1:0]  idx_q;

   logic [3:0]       nibA;
   logic [3:0]       nibB;
   logic [3:0]       adderSum;
   logic             adderCout;
   logic             accept;
   logic             lastNibble;

   assign accept     = in_valid && (state_q == IDLE);
   assign lastNibble = (idx_q == IDX_LAST);

   // Select the current nibble of each operand; the index is the only mux
   // in front of the ripple adder.
   assign nibA = opA_q[{idx_q, 2'b00} +: 4];
   assign nibB = opB_q[{idx_q, 2'b00} +: 4];

   four_bit_adder u_adder (
      .A    (nibA),
      .B    (nibB),
      .Cin  (carry_q),
      .Sum  (adderSum),
      .Cout (adderCout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept in IDLE, step nibbles in RUN, wait for the
   // consumer in DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)   state_d = RUN;
         RUN:     if (lastNibble) state_d = DONE;
         DONE:    if (out_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decode registered state only, so neither depends
   // combinationally on in_valid or out_ready.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // Datapath: operands and carry are captured on accept; each RUN cycle
   // writes one result nibble and forwards the nibble carry. The result
   // register is not cleared on accept, so during RUN out_sum shows the
   // nibbles written so far over the previous result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA_q    <= '0;
         opB_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
      end else if (accept) begin
         opA_q   <= in_a;
         opB_q   <= in_b;
         carry_q <= in_cin;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         result_q[{idx_q, 2'b00} +: 4] <= adderSum;
         carry_q                        <= adderCout;
         idx_q                          <= idx_q + IDX_ONE;
      end
   end

   assign out_sum  = result_q;
   assign out_cout = carry_q;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic ovf_q;
   logic carryIntoTop;

   // On the last nibble, Sum[3] is result bit WIDTH-1, so the carry into the
   // top bit can be recovered from a ^ b ^ sum at that bit.
   assign carryIntoTop = opA_q[WIDTH-1] ^ opB_q[WIDTH-1] ^ adderSum[3];

   // Overflow is captured on the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if ((state_q == RUN) && lastNibble) begin
         ovf_q <= adderCout ^ carryIntoTop;
      end
   end

   assign out_ovf = ovf_q;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed bench for nibble_serial_adder. Drives a 16-bit instance through
// basic add, full carry ripple, signed overflow, backpressure with ignored
// requests, and asynchronous reset mid-operation; a 4-bit instance covers
// the single-nibble case. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------

module tb_nibble_serial_adder;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic        clk;
   logic        rst_n;

   logic        inValid;
   logic        inReady;
   logic [15:0] inA;
   logic [15:0] inB;
   logic        inCin;
   logic        outValid;
   logic        outReady;
   logic [15:0] outSum;
   logic        outCout;
   logic        outOvf;

   logic        inValid4;
   logic        inReady4;
   logic [3:0]  inA4;
   logic [3:0]  inB4;
   logic        inCin4;
   logic        outValid4;
   logic        outReady4;
   logic [3:0]  outSum4;
   logic        outCout4;
   logic        outOvf4;

   int total;
   int bad;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_a      (inA),
      .in_b      (inB),
      .in_cin    (inCin),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_sum   (outSum),
      .out_cout  (outCout),
      .out_ovf   (outOvf)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid4),
      .in_ready  (inReady4),
      .in_a      (inA4),
      .in_b      (inB4),
      .in_cin    (inCin4),
      .out_valid (outValid4),
      .out_ready (outReady4),
      .out_sum   (outSum4),
      .out_cout  (outCout4),
      .out_ovf   (outOvf4)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: count it, and on mismatch count and report the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Wait (bounded) for in_ready, then present operands for exactly one edge.
   task automatic applyStimulus(input string tag, input logic [15:0] a,
                                input logic [15:0] b, input logic cin);
      int waited;
      waited = 0;
      while (!inReady && waited < 50) begin
         tick();
         waited++;
      end
      if (!inReady) checkOutput({tag, "_ready_timeout"}, 32'(inReady), 32'd1);
      inValid = 1'b1;
      inA     = a;
      inB     = b;
      inCin   = cin;
      tick();
      inValid = 1'b0;
      inA     = 16'hDEAD;
      inB     = 16'hBEEF;
      inCin   = 1'b0;
   endtask

   // Full 16-bit operation: accept, exact 4-cycle latency, result, handshake.
   task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] expSum,
                        input logic expCout, input logic expOvf);
      applyStimulus(tag, a, b, cin);
      for (int c = 1; c <= 3; c++) begin
         tick();
         checkOutput({tag, "_valid_early"}, 32'(outValid), 32'd0);
      end
      tick();
      checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, "_sum"},   32'(outSum),   32'(expSum));
      checkOutput({tag, "_cout"},  32'(outCout),  32'(expCout));
      checkOutput({tag, "_ovf"},   32'(outOvf),   32'(expOvf & OVF_ON));
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkOutput({tag, "_valid_drop"}, 32'(outValid), 32'd0);
      checkOutput({tag, "_ready_back"}, 32'(inReady),  32'd1);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      inValid   = 1'b0;
      inA       = '0;
      inB       = '0;
      inCin     = 1'b0;
      outReady  = 1'b0;
      inValid4  = 1'b0;
      inA4      = '0;
      inB4      = '0;
      inCin4    = 1'b0;
      outReady4 = 1'b0;

      // Reset state
      #2;
      checkOutput("rst_in_ready",  32'(inReady),  32'd1);
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_sum",       32'(outSum),   32'd0);
      checkOutput("rst_cout",      32'(outCout),  32'd0);
      checkOutput("rst_ovf",       32'(outOvf),   32'd0);
      #10;
      rst_n = 1'b1;
      tick();
      checkOutput("idle_hold", 32'(inReady), 32'd1);

      // Basic add, carry ripple through every nibble, signed overflow
      runOp("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      runOp("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      runOp("sovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

      // Backpressure: A5A5 + 5A5A + 1 = 0x1_0000; in_valid pulses in RUN and
      // DONE must be ignored.
      applyStimulus("bp", 16'hA5A5, 16'h5A5A, 1'b1);
      inValid = 1'b1;
      inA     = 16'h1111;
      inB     = 16'h2222;
      inCin   = 1'b1;
      tick();
      inValid = 1'b0;
      checkOutput("bp_run_ready", 32'(inReady), 32'd0);
      tick();
      tick();
      tick();
      checkOutput("bp_valid", 32'(outValid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         inValid = (c == 2);
         checkOutput("bp_hold_valid", 32'(outValid), 32'd1);
         checkOutput("bp_hold_sum",   32'(outSum),   32'h0000);
         checkOutput("bp_hold_cout",  32'(outCout),  32'd1);
         checkOutput("bp_hold_ready", 32'(inReady),  32'd0);
         checkOutput("bp_hold_ovf",   32'(outOvf),   32'd0);
         tick();
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkOutput("bp_release_valid", 32'(outValid), 32'd0);
      checkOutput("bp_release_ready", 32'(inReady),  32'd1);
      tick();
      checkOutput("bp_stay_idle", 32'(inReady), 32'd1);

      // Reset after two RUN edges: low byte 0x55 is written, then abort.
      applyStimulus("rstrun", 16'h1234, 16'h4321, 1'b0);
      tick();
      tick();
      checkOutput("rstrun_partial", 32'(outSum), 32'h0055);
      rst_n = 1'b0;
      #1;
      checkOutput("rstrun_valid", 32'(outValid), 32'd0);
      checkOutput("rstrun_sum",   32'(outSum),   32'd0);
      checkOutput("rstrun_cout",  32'(outCout),  32'd0);
      checkOutput("rstrun_ovf",   32'(outOvf),   32'd0);
      #4;
      rst_n = 1'b1;
      tick();
      checkOutput("rstrun_ready", 32'(inReady), 32'd1);
      runOp("postrst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);

      // Minimal width: F + F + 1 = 0x1F, one-cycle latency
      inValid4 = 1'b1;
      inA4     = 4'hF;
      inB4     = 4'hF;
      inCin4   = 1'b1;
      tick();
      inValid4 = 1'b0;
      inA4     = 4'h0;
      inB4     = 4'h0;
      inCin4   = 1'b0;
      checkOutput("w4_run_valid", 32'(outValid4), 32'd0);
      checkOutput("w4_run_ready", 32'(inReady4),  32'd0);
      tick();
      checkOutput("w4_valid", 32'(outValid4), 32'd1);
      checkOutput("w4_sum",   32'(outSum4),   32'hF);
      checkOutput("w4_cout",  32'(outCout4),  32'd1);
      checkOutput("w4_ovf",   32'(outOvf4),   32'd0);
      outReady4 = 1'b1;
      tick();
      outReady4 = 1'b0;
      checkOutput("w4_ready_back", 32'(inReady4), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle adder that accepts two WIDTH-bit operands through a valid/ready handshake. It adds them one nibble per cycle through a single instantiated `four_bit_adder`, with the `four_bit_adder` ports `A`, `B`, `Cin`, `Sum` and `Cout`. The carry between nibbles is held in a register. The block sits directly upstream of the 4-bit adder: it slices the operands, drives the adder, and collects its sum and carry into a full-width result. This gives wide additions at the area cost of one ripple-carry nibble.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and at least 4. NIB = WIDTH/4.
- `clk`  in  1  rising-edge clock. This is the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands. High only in IDLE.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_cin`  in  1  carry-in into bit 0.
- `out_valid`  out  1  result available. High only in DONE.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  WIDTH  sum, modulo 2^WIDTH.
- `out_cout`  out  1  carry out of bit WIDTH-1.
- `out_ovf`  out  1  two's-complement overflow flag (see Configuration).

## Operation
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` & `in_ready` at a clock edge: latch `in_a` and `in_b`, load the carry register with `in_cin`, clear the nibble index to 0, and go to RUN.
- RUN, one nibble per cycle:
  - The adder receives `a[4i+3:4i]`, `b[4i+3:4i]` and the carry register, where i is the nibble index.
  - At the clock edge: `Sum` is written into result bits `[4i+3:4i]`, the carry register takes `Cout`, and i increments.
  - When i = NIB-1 at the edge, go to DONE. The carry register then holds the final carry out.
- DONE:
  - `out_valid` = 1.
  - `out_sum`, `out_cout` and `out_ovf` are held stable until `out_valid` & `out_ready`; then go to IDLE.
- `in_valid` outside IDLE is ignored, and the operands are not sampled.
- Overflow: `ovf` = final carry XOR carry into bit WIDTH-1. The carry into bit WIDTH-1 is computed as `a[W-1]` ^ `b[W-1]` ^ `sum[W-1]` and registered on entry to DONE.
- Output values are meaningful only while `out_valid` = 1. During RUN, `out_sum` shows the partially written result register.
- Reset asserted at any time, including mid-RUN or in DONE:
  - Operation is aborted and its result discarded.
  - State = IDLE; operand, result, carry and index registers = 0.
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_cout` = 0, `out_ovf` = 0.

## Timing
- Accept at edge k; RUN occupies edges k+1 through k+NIB.
- `out_valid` rises after edge k+NIB, giving a latency of NIB cycles.
- Result handshake at edge m → IDLE after m. The next accept is possible at edge m+1 at the earliest.
- Minimum issue interval is NIB+2 cycles.
- The adder path is purely combinational within each RUN cycle. The critical path is index mux → 4-bit ripple → result/carry registers.
- `in_ready` and `out_valid` are decoded from registered state only. Neither depends combinationally on `in_valid` or `out_ready`.

## Configuration
- Macro: `NIBBLE_SERIAL_ADDER_OVF_EN`.
- Defined: the overflow register and logic are present, and `out_ovf` behaves as specified in Operation.
- Undefined: the overflow logic is omitted and `out_ovf` is tied to 0. All other behaviour and timing are identical.

## Test plan
- **Basic add:** WIDTH=16, `in_a`=0x1234, `in_b`=0x4321, `in_cin`=0 → `out_sum`=0x5555, `out_cout`=0, `out_valid` high exactly 4 cycles after accept.
- **Carry ripple across all nibbles:** `in_a`=0xFFFF, `in_b`=0x0001, `in_cin`=0 → `out_sum`=0x0000, `out_cout`=1, `out_ovf`=0.
- **Signed overflow:** `in_a`=0x7FFF, `in_b`=0x0001 → `out_sum`=0x8000, `out_cout`=0; `out_ovf`=1 with the macro defined, 0 without.
- **Backpressure:** hold `out_ready` low for 5 cycles in DONE → `out_valid`, `out_sum` and `out_cout` stable and `in_ready`=0 throughout. A new `in_valid` pulse during RUN or DONE is ignored.
- **Reset mid-operation:** deassert `rst_n` after 2 RUN cycles → `out_valid`=0 and all outputs 0 immediately; `in_ready`=1 after release. The next operation, 0x00FF + 0x0F01, gives 0x1000.
- **Minimal width:** WIDTH=4, `in_a`=0xF, `in_b`=0xF, `in_cin`=1 → `out_sum`=0xF, `out_cout`=1, latency 1 cycle.
